// File: rtl/or_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : or_gate_pkg
// Description : Shared types and helpers for the or_gate_unit block.
//               - mode_t          : per-input operating mode (pass / sticky)
//               - c_default_width : default operand width
//               - popcnt_width()  : bits needed to hold a count 0..width
// Revision    : 1.0  initial release
// ============================================================================
package or_gate_pkg;

    localparam int c_default_width = 1;

    typedef enum logic {
        MODE_PASS = 1'b0,
        MODE_ACC  = 1'b1
    } mode_t;

    // Equivalent to $clog2(width+1), clamped to at least one bit so the
    // 1-bit configuration still gets a usable count port. Bounded loop keeps
    // it a legal constant function for any legal WIDTH (1..64).
    function automatic int popcnt_width(input int width);
        int w;
        w = 1;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < (width + 1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage : or_gate_pkg
`default_nettype wire

// File: rtl/or_gate_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : or_gate_unit_if
// Description : Operand / result bundle for or_gate_unit.
//               master : drives a, b, in_valid, acc_mode, clear
//               slave  : drives c, out_valid, any_c (and popcnt)
//               Optional macro OR_GATE_UNIT_POPCOUNT_EN adds popcnt.
// Revision    : 1.0  initial release
// ============================================================================
interface or_gate_unit_if
    import or_gate_pkg::*;
#(
    parameter int WIDTH = c_default_width
);

    localparam int c_popcnt_w = popcnt_width(WIDTH);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             acc_mode;
    logic             clear;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             any_c;
`ifdef OR_GATE_UNIT_POPCOUNT_EN
    logic [c_popcnt_w-1:0] popcnt;

    modport master (
        output a, b, in_valid, acc_mode, clear,
        input  c, out_valid, any_c, popcnt
    );

    modport slave (
        input  a, b, in_valid, acc_mode, clear,
        output c, out_valid, any_c, popcnt
    );
`else
    modport master (
        output a, b, in_valid, acc_mode, clear,
        input  c, out_valid, any_c
    );

    modport slave (
        input  a, b, in_valid, acc_mode, clear,
        output c, out_valid, any_c
    );
`endif

endinterface : or_gate_unit_if
`default_nettype wire

// File: rtl/or_gate_popcount.sv
`default_nettype none
// ============================================================================
// Module      : or_gate_popcount
// Description : Combinational population counter over a WIDTH-bit vector.
// Ports       : vec  (in)  WIDTH-bit input vector
//               cnt  (out) number of ones in vec
// Revision    : 1.0  initial release
// ============================================================================
module or_gate_popcount
    import or_gate_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = popcnt_width(WIDTH)
) (
    input  wire logic [WIDTH-1:0] vec,
    output logic      [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum = w_sum + CNT_W'(vec[i]);
        end
    end

    assign cnt = w_sum;

endmodule : or_gate_popcount
`default_nettype wire

// File: rtl/or_gate_unit.sv
`default_nettype none
// ============================================================================
// Module      : or_gate_unit
// Description : Registered bitwise OR of two operands with optional sticky
//               accumulation. One-cycle latency from accepted input to c.
// Ports       : clk  rising-edge clock
//               rst  asynchronous active-high reset
//               bus  or_gate_unit_if.slave
//                    a, b      operands
//                    in_valid  operands valid this cycle
//                    acc_mode  0 = pass (c <= a|b), 1 = sticky (c <= c|a|b)
//                    clear     synchronous clear of c / out_valid
//                    c         registered result
//                    out_valid c holds a result from an accepted input
//                    any_c     reduction OR of c
//                    popcnt    ones count of c (OR_GATE_UNIT_POPCOUNT_EN only)
// Config      : define OR_GATE_UNIT_POPCOUNT_EN to build the popcnt logic.
// Revision    : 1.0  initial release
// ============================================================================
module or_gate_unit
    import or_gate_pkg::*;
#(
    parameter int               WIDTH     = c_default_width,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    or_gate_unit_if.slave bus
);

    logic [WIDTH-1:0] r_c;
    logic             r_out_valid;
    mode_t            w_mode;
    logic [WIDTH-1:0] w_next_c;

    assign w_mode = mode_t'(bus.acc_mode);

    // Sticky mode folds the current value in, so once every bit is set the
    // register naturally stays all-ones until clear or reset.
    always_comb begin
        w_next_c = bus.a | bus.b;
        if (w_mode == MODE_ACC) begin
            w_next_c = r_c | bus.a | bus.b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c         <= RESET_VAL;
            r_out_valid <= 1'b0;
        end else if (bus.clear) begin
            r_c         <= RESET_VAL;
            r_out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            r_c         <= w_next_c;
            r_out_valid <= 1'b1;
        end
    end

    assign bus.c         = r_c;
    assign bus.out_valid = r_out_valid;
    assign bus.any_c     = |r_c;

`ifdef OR_GATE_UNIT_POPCOUNT_EN
    or_gate_popcount #(
        .WIDTH (WIDTH),
        .CNT_W (popcnt_width(WIDTH))
    ) u_popcount (
        .vec (r_c),
        .cnt (bus.popcnt)
    );
`endif

endmodule : or_gate_unit
`default_nettype wire

// File: tb/tb_or_gate_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_or_gate_unit
// Description : Scoreboard bench for or_gate_unit: a 1-bit and an 8-bit
//               instance driven by directed vectors with hand-computed
//               expected results.
// Revision    : 1.0  initial release
// ============================================================================
module tb_or_gate_unit;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    or_gate_unit_if #(.WIDTH(1)) if1 ();
    or_gate_unit_if #(.WIDTH(8)) if8 ();

    or_gate_unit #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    or_gate_unit #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         sel8;
        string      name;
        logic [7:0] c;
        logic       ov;
        logic       any;
        logic [3:0] pc;
    } exp_t;

    exp_t q[$];
    exp_t e;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_dut(input bit sel8, input string name, input logic [7:0] ec,
                           input logic eov, input logic eany, input logic [3:0] epc);
        if (sel8) begin
            chk({name, ".c"}, if8.c, ec);
            chk({name, ".out_valid"}, {7'd0, if8.out_valid}, {7'd0, eov});
            chk({name, ".any_c"}, {7'd0, if8.any_c}, {7'd0, eany});
`ifdef OR_GATE_UNIT_POPCOUNT_EN
            chk({name, ".popcnt"}, {4'd0, if8.popcnt}, {4'd0, epc});
`endif
        end else begin
            chk({name, ".c"}, {7'd0, if1.c}, ec);
            chk({name, ".out_valid"}, {7'd0, if1.out_valid}, {7'd0, eov});
            chk({name, ".any_c"}, {7'd0, if1.any_c}, {7'd0, eany});
`ifdef OR_GATE_UNIT_POPCOUNT_EN
            chk({name, ".popcnt"}, {7'd0, if1.popcnt}, {4'd0, epc});
`endif
        end
    endtask

    // Monitor: one expectation per driven cycle, compared just after the
    // edge that captured the stimulus.
    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk_dut(e.sel8, e.name, e.c, e.ov, e.any, e.pc);
        end
    end

    task automatic push(input bit sel8, input string name, input logic [7:0] ec,
                        input logic eov, input logic [3:0] epc);
        exp_t x;
        x.sel8 = sel8;
        x.name = name;
        x.c    = ec;
        x.ov   = eov;
        x.any  = |ec;
        x.pc   = epc;
        q.push_back(x);
    endtask

    task automatic step8(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic v, input logic acc, input logic clr,
                         input logic [7:0] ec, input logic eov, input logic [3:0] epc);
        @(negedge clk);
        if1.in_valid = 1'b0;
        if1.clear    = 1'b0;
        if8.a        = a;
        if8.b        = b;
        if8.in_valid = v;
        if8.acc_mode = acc;
        if8.clear    = clr;
        push(1'b1, name, ec, eov, epc);
    endtask

    task automatic step1(input string name, input logic a, input logic b,
                         input logic ec);
        @(negedge clk);
        if8.in_valid = 1'b0;
        if8.clear    = 1'b0;
        if1.a        = a;
        if1.b        = b;
        if1.in_valid = 1'b1;
        if1.acc_mode = 1'b0;
        if1.clear    = 1'b0;
        push(1'b0, name, {7'd0, ec}, 1'b1, {3'd0, ec});
    endtask

    initial begin
        rst = 1'b1;
        if1.a = '0; if1.b = '0; if1.in_valid = 1'b0; if1.acc_mode = 1'b0; if1.clear = 1'b0;
        if8.a = '0; if8.b = '0; if8.in_valid = 1'b0; if8.acc_mode = 1'b0; if8.clear = 1'b0;

        #1;
        chk_dut(1'b0, "reset1", 8'h00, 1'b0, 1'b0, 4'd0);
        chk_dut(1'b1, "reset8", 8'h00, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1-bit truth table
        step1("w1_00", 1'b0, 1'b0, 1'b0);
        step1("w1_01", 1'b0, 1'b1, 1'b1);
        step1("w1_10", 1'b1, 1'b0, 1'b1);
        step1("w1_11", 1'b1, 1'b1, 1'b1);

        // 8-bit pass mode
        step8("pass_ff", 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 4'd8);
        step8("pass_00", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0);

        // accumulate
        step8("acc_01", 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 4'd1);
        step8("acc_11", 8'h00, 8'h10, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 4'd2);
        step8("acc_91", 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 8'h91, 1'b1, 4'd3);

        // hold with in_valid low
        for (int i = 0; i < 5; i++) begin
            step8("hold", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h91, 1'b1, 4'd3);
        end

        // asynchronous reset between edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_dut(1'b1, "async_rst", 8'h00, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        step8("post_rst", 8'h03, 8'h04, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 4'd3);

        // clear beats in_valid
        step8("clear_pri", 8'hAA, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 4'd0);

        // saturation, then mode switch back to pass
        step8("acc_sat", 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 4'd8);
        step8("sat_hold", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 4'd8);
        step8("mode_sw", 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 4'd1);

        @(negedge clk);
        if8.in_valid = 1'b0;
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        chk("scoreboard_drain", 8'(q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_or_gate_unit
`default_nettype wire

// File: doc/or_gate_unit.md
Name: or_gate_unit

Overview:
- Clocked, parameterizable bitwise-OR unit; c registers a|b one cycle after a valid input.
- Optional sticky-accumulate mode ORs successive inputs into the output register.
- Used as a small datapath primitive and bring-up block, with a 1-bit configuration matching a plain 2-input OR truth table.

Parameters:
- WIDTH, 1, bit width of a, b, c (legal 1..64).
- RESET_VAL, '0, value loaded into c on reset and on clear.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  a/b are valid this cycle.
- acc_mode  input  1  0 = pass mode, 1 = accumulate (sticky) mode.
- clear  input  1  synchronous clear of c and out_valid.
- c  output  WIDTH  registered result.
- out_valid  output  1  c holds a result produced by an accepted input.
- any_c  output  1  reduction OR of c (combinational from register).
- popcnt  output  $clog2(WIDTH+1)  number of ones in c; present only with the optional feature.

Behaviour:
- Reset (rst=1, asynchronous assert, released synchronously by the system):
  - c=RESET_VAL, out_valid=0.
  - any_c and popcnt reflect RESET_VAL.
- Latency: exactly 1 clk from an accepted input to the updated c and out_valid.
- Accepted input: in_valid=1 at a rising edge with rst=0 and clear=0.
  - Pass mode (acc_mode=0): c <= a | b; out_valid <= 1.
  - Accumulate mode (acc_mode=1): c <= c | a | b; out_valid <= 1.
- in_valid=0: c and out_valid hold; a/b are ignored, including X values.
- Priority: rst > clear > in_valid.
  - clear=1: c <= RESET_VAL, out_valid <= 0, whatever in_valid is.
- acc_mode is sampled per accepted input; switching modes mid-stream has no extra side effects.
- Accumulate saturation: once all bits of c are 1, c stays all-ones until clear or reset.
- any_c = |c; popcnt = sum of c bits. Both are derived from the register with no added latency.
- Reset asserted mid-operation: outputs go to reset values immediately, not at the clock edge.
- No backpressure: every valid input is accepted.

Optional Feature:
- Macro: OR_GATE_UNIT_POPCOUNT_EN.
- Defined: popcnt port and logic present; popcnt = count of ones in c, same timing as any_c.
- Undefined: popcnt port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package or_gate_pkg:
  - mode enum (MODE_PASS=0, MODE_ACC=1).
  - function clog2-width helper for the popcnt width.
  - default WIDTH constant.
- One natural sub-module: or_gate_popcount, a combinational WIDTH-bit population counter, instantiated only under the macro.

Test Plan:
- WIDTH=1, pass mode, in_valid=1: apply a,b = 00,01,10,11 on successive cycles -> c = 0,1,1,1 one cycle later each; out_valid=1 from the first result.
- WIDTH=8, pass mode: a=0x0F, b=0xF0 -> c=0xFF, any_c=1, popcnt=8; then a=0x00, b=0x00 -> c=0x00, any_c=0, popcnt=0.
- WIDTH=8, accumulate mode: send (0x01,0x00), then (0x00,0x10), then (0x80,0x00) -> c = 0x01, 0x11, 0x91; popcnt=3.
- Hold: set in_valid=0 and drive a=0xFF, b=0xFF -> c and out_valid unchanged for 5 cycles.
- Clear priority: clear=1 together with in_valid=1, a=0xAA -> next cycle c=RESET_VAL and out_valid=0.
- Async reset: assert rst between clock edges while c=0x91 -> c=0x00 and out_valid=0 before the next edge; after release, the first accepted input gives a normal result.
